keypad_scanner: RTL and testbench

- Parametrised matrix-keypad scanner and decoder for the calculator front end.
- Drives one active-low column at a time and samples active-low rows through a synchroniser.
- Debounces press and release; emits one single-cycle key event per physical press with a hex key code.
- Generalises the fixed 4x4 DE2 decode to ROWS x COLS, with selectable face-value or linear code mapping.

---
 rtl/keypad_scanner.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks one active-low column per sample tick, debounces
// press and release on the synchronised rows, and emits one event per keystroke.
module keypad_scanner #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int CODE_W   = 4,
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4,
   parameter int MAP_HEX  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROWS-1:0]   row_n,
   output logic [COLS-1:0]   col_n,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic              multi_err
);
   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int NW = $clog2(ROWS + 1);

   // DE2 face values, indexed by {column, row}
   localparam logic [3:0] HEX_LUT [16] = '{
      4'h1, 4'h4, 4'h7, 4'hA,
      4'h2, 4'h5, 4'h8, 4'h0,
      4'h3, 4'h6, 4'h9, 4'hB,
      4'hF, 4'hE, 4'hD, 4'hC};

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

   state_t            st, st_nx;
   logic [ROWS-1:0]   rs_m, rs;
   logic [TW-1:0]     tcnt;
   logic              tick;
   logic [DW-1:0]     dcnt, dcnt_nx, dcnt_inc;
   logic [CW-1:0]     col, col_nx, col_adv;
   logic [RW-1:0]     r_lat, r_nx, low_idx;
   logic [NW-1:0]     nlow;
   logic              none, one, multi;
   logic [CODE_W-1:0] code_nx;
   logic              vld_nx, held_nx, merr_nx;

   function automatic logic [CODE_W-1:0] map_key(input logic [CW-1:0] c, input logic [RW-1:0] r);
      logic [7:0] cc, rr;
      int         lin;
      cc  = 8'(c);
      rr  = 8'(r);
      lin = int'(cc) * ROWS + int'(rr);
      if (MAP_HEX != 0) return CODE_W'(HEX_LUT[{cc[1:0], rr[1:0]}]);
      return CODE_W'(lin);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_m <= '1;
         rs   <= '1;
         tcnt <= '0;
      end else begin
         rs_m <= row_n;
         rs   <= rs_m;
         tcnt <= tick ? '0 : tcnt + TW'(1);
      end
   end

   assign tick = (tcnt == TW'(SCAN_DIV - 1));

   always_comb begin
      nlow    = '0;
      low_idx = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (!rs[i]) begin
            nlow    = nlow + NW'(1);
            low_idx = RW'(i);
         end
      end
   end

   assign none     = (nlow == '0);
   assign one      = (nlow == NW'(1));
   assign multi    = (nlow > NW'(1));
   assign dcnt_inc = dcnt + DW'(1);
   assign col_adv  = (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
   assign col_n    = ~(COLS'(1) << col);

   always_comb begin
      st_nx   = st;
      dcnt_nx = dcnt;
      col_nx  = col;
      r_nx    = r_lat;
      code_nx = key_code;
      vld_nx  = 1'b0;
      held_nx = key_held;
      merr_nx = multi_err;
      if (tick) begin
         merr_nx = multi;
         case (st)
            SCAN: begin
               if (none) begin
                  col_nx = col_adv;
               end else if (one) begin
                  r_nx    = low_idx;
                  dcnt_nx = DW'(1);
                  if (DEBOUNCE == 1) begin
                     code_nx = map_key(col, low_idx);
                     vld_nx  = 1'b1;
                     held_nx = 1'b1;
                     st_nx   = HELD;
                  end else begin
                     st_nx = DEB_PRESS;
                  end
               end
            end
            DEB_PRESS: begin
               if (one && low_idx == r_lat) begin
                  dcnt_nx = dcnt_inc;
                  if (dcnt_inc == DW'(DEBOUNCE)) begin
                     code_nx = map_key(col, r_lat);
                     vld_nx  = 1'b1;
                     held_nx = 1'b1;
                     st_nx   = HELD;
                  end
               end else begin
                  st_nx = SCAN;
               end
            end
            HELD: begin
               // extra rows while held only raise multi_err, never a new event
               if (none) begin
                  dcnt_nx = DW'(1);
                  if (DEBOUNCE == 1) begin
                     held_nx = 1'b0;
                     col_nx  = col_adv;
                     st_nx   = SCAN;
                  end else begin
                     st_nx = DEB_REL;
                  end
               end
            end
            DEB_REL: begin
               if (none) begin
                  dcnt_nx = dcnt_inc;
                  if (dcnt_inc == DW'(DEBOUNCE)) begin
                     held_nx = 1'b0;
                     col_nx  = col_adv;
                     st_nx   = SCAN;
                  end
               end else begin
                  st_nx = HELD;
               end
            end
            default: st_nx = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= SCAN;
         dcnt      <= '0;
         col       <= '0;
         r_lat     <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         st        <= st_nx;
         dcnt      <= dcnt_nx;
         col       <= col_nx;
         r_lat     <= r_nx;
         key_code  <= code_nx;
         key_valid <= vld_nx;
         key_held  <= held_nx;
         multi_err <= merr_nx;
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 face-map instance and a 3x5 linear instance
// driven by a switch-matrix model, checked tick by tick against keystroke rules.
module tb_keypad_scanner;
   localparam int SD = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] row_n, col_n, key_code;
   logic       key_valid, key_held, multi_err;
   logic [2:0] row_n_l;
   logic [4:0] col_n_l;
   logic [3:0] key_code_l;
   logic       key_valid_l, key_held_l, multi_err_l;

   logic [3:0][3:0] keys   = '0;   // keys[row][col], 1 = closed
   logic [2:0][4:0] keys_l = '0;

   int n_cmp = 0;
   int n_err = 0;
   int mcol[2] = '{0, 0};
   int vcnt[2] = '{0, 0};
   int face[4][4] = '{'{1, 2, 3, 15}, '{4, 5, 6, 14}, '{7, 8, 9, 13}, '{10, 0, 11, 12}};

   keypad_scanner #(.ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(SD), .DEBOUNCE(4), .MAP_HEX(1)) dut (
      .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .key_code(key_code),
      .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err));

   keypad_scanner #(.ROWS(3), .COLS(5), .CODE_W(4), .SCAN_DIV(SD), .DEBOUNCE(2), .MAP_HEX(0)) dut_l (
      .clk(clk), .rst(rst), .row_n(row_n_l), .col_n(col_n_l), .key_code(key_code_l),
      .key_valid(key_valid_l), .key_held(key_held_l), .multi_err(multi_err_l));

   // a closed switch pulls its row low only while its column is driven
   always_comb begin
      for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r] & ~col_n);
      for (int r = 0; r < 3; r++) row_n_l[r] = ~|(keys_l[r] & ~col_n_l);
   end

   always @(posedge clk) begin
      #1;
      if (key_valid === 1'b1) vcnt[0]++;
      if (key_valid_l === 1'b1) vcnt[1]++;
   end

   function automatic int ncols(input bit lin);
      return lin ? 5 : 4;
   endfunction

   function automatic logic [4:0] cur_col(input bit lin);
      return lin ? col_n_l : {1'b1, col_n};
   endfunction

   function automatic logic [4:0] exp_col(input int c);
      logic [4:0] v;
      v = 5'b11111;
      v[c] = 1'b0;
      return v;
   endfunction

   function automatic logic [3:0] cur_code(input bit lin);
      return lin ? key_code_l : key_code;
   endfunction

   function automatic logic cur_held(input bit lin);
      return lin ? key_held_l : key_held;
   endfunction

   function automatic int exp_code(input bit lin, input int c, input int r);
      return lin ? (c * 3 + r) : face[r][c];
   endfunction

   task automatic set_key(input bit lin, input int r, input int c, input logic v);
      if (lin) keys_l[r][c] = v;
      else keys[r][c] = v;
   endtask

   // one full column dwell: ends just after the tick's effects are visible
   task automatic step();
      repeat (SD) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic goto_col(input bit lin, input int c);
      while (mcol[lin] != c) begin
         step();
         mcol[lin] = (mcol[lin] + 1) % ncols(lin);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      keys = '0;
      keys_l = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mcol = '{0, 0};
   endtask

   task automatic test_reset();
      logic [4:0] ex;
      do_reset();
      step();
      step();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({col_n, key_code, key_valid, key_held, multi_err} !== 11'b1110_0000_000) begin
         n_err++;
         $display("FAIL reset_outputs: got %b required %b", {col_n, key_code, key_valid, key_held, multi_err}, 11'b1110_0000_000);
      end
      n_cmp++;
      if (col_n_l !== 5'b11110) begin
         n_err++;
         $display("FAIL reset_col_lin: got %b required 11110", col_n_l);
      end
      @(negedge clk);
      rst = 1'b0;
      mcol = '{0, 0};
      for (int i = 1; i <= 5; i++) begin
         step();
         mcol[0] = i % 4;
         ex = exp_col(mcol[0]);
         n_cmp++;
         if (col_n !== ex[3:0]) begin
            n_err++;
            $display("FAIL scan_seq_%0d: got %b required %b", i, col_n, ex[3:0]);
         end
      end
   endtask

   task automatic test_clean_press();
      int v0;
      goto_col(0, 1);
      v0 = vcnt[0];
      keys[0][1] = 1'b1;
      repeat (3) step();
      n_cmp++;
      if (vcnt[0] != v0 || key_held !== 1'b0) begin
         n_err++;
         $display("FAIL press_early: events %0d held %b required 0 and 0", vcnt[0] - v0, key_held);
      end
      step();
      n_cmp++;
      if (vcnt[0] != v0 + 1 || key_code !== 4'h2 || key_held !== 1'b1) begin
         n_err++;
         $display("FAIL press_accept: events %0d code %h held %b required 1, 2, 1", vcnt[0] - v0, key_code, key_held);
      end
      repeat (5) step();
      n_cmp++;
      if (vcnt[0] != v0 + 1 || key_held !== 1'b1 || col_n !== 4'b1101) begin
         n_err++;
         $display("FAIL press_hold: events %0d held %b col %b required 1, 1, 1101", vcnt[0] - v0, key_held, col_n);
      end
      keys[0][1] = 1'b0;
      repeat (4) step();
      mcol[0] = 2;
      n_cmp++;
      if (key_held !== 1'b0 || col_n !== 4'b1011) begin
         n_err++;
         $display("FAIL press_release: held %b col %b required 0, 1011", key_held, col_n);
      end
   endtask

   task automatic test_bounce();
      int v0;
      goto_col(0, 2);
      v0 = vcnt[0];
      for (int k = 0; k < 10; k++) begin
         keys[2][2] = (k % 2 == 0);
         step();
      end
      n_cmp++;
      if (vcnt[0] != v0 || col_n !== 4'b1011) begin
         n_err++;
         $display("FAIL bounce_quiet: events %0d col %b required 0, 1011", vcnt[0] - v0, col_n);
      end
      keys[2][2] = 1'b1;
      repeat (3) step();
      n_cmp++;
      if (vcnt[0] != v0) begin
         n_err++;
         $display("FAIL bounce_early: events %0d required 0", vcnt[0] - v0);
      end
      step();
      n_cmp++;
      if (vcnt[0] != v0 + 1 || key_code !== 4'h9) begin
         n_err++;
         $display("FAIL bounce_accept: events %0d code %h required 1, 9", vcnt[0] - v0, key_code);
      end
   endtask

   task automatic test_release();
      logic pat [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 8; k++) begin
         keys[2][2] = pat[k];
         step();
         n_cmp++;
         if (key_held !== (k < 7)) begin
            n_err++;
            $display("FAIL release_tick_%0d: held %b required %b", k, key_held, k < 7);
         end
      end
      mcol[0] = 3;
      n_cmp++;
      if (col_n !== 4'b0111) begin
         n_err++;
         $display("FAIL release_next_col: got %b required 0111", col_n);
      end
   endtask

   task automatic test_multi();
      int v0;
      goto_col(0, 0);
      v0 = vcnt[0];
      keys[0][0] = 1'b1;
      keys[3][0] = 1'b1;
      repeat (3) step();
      n_cmp++;
      if (multi_err !== 1'b1 || col_n !== 4'b1110 || vcnt[0] != v0) begin
         n_err++;
         $display("FAIL multi_set: merr %b col %b events %0d required 1, 1110, 0", multi_err, col_n, vcnt[0] - v0);
      end
      keys[3][0] = 1'b0;
      step();
      n_cmp++;
      if (multi_err !== 1'b0 || vcnt[0] != v0) begin
         n_err++;
         $display("FAIL multi_clear: merr %b events %0d required 0, 0", multi_err, vcnt[0] - v0);
      end
      repeat (3) step();
      n_cmp++;
      if (vcnt[0] != v0 + 1 || key_code !== 4'h1) begin
         n_err++;
         $display("FAIL multi_accept: events %0d code %h required 1, 1", vcnt[0] - v0, key_code);
      end
      keys[0][0] = 1'b0;
      repeat (4) step();
      mcol[0] = 1;
   endtask

   task automatic test_reset_mid_press();
      int v0;
      goto_col(0, 3);
      keys[1][3] = 1'b1;
      repeat (3) step();
      v0 = vcnt[0];
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
         n_err++;
         $display("FAIL midpress_reset: held %b valid %b code %h required 0, 0, 0", key_held, key_valid, key_code);
      end
      @(negedge clk);
      rst = 1'b0;
      mcol = '{0, 0};
      goto_col(0, 3);
      repeat (3) step();
      n_cmp++;
      if (vcnt[0] != v0) begin
         n_err++;
         $display("FAIL midpress_noevent: events %0d required 0", vcnt[0] - v0);
      end
      step();
      n_cmp++;
      if (vcnt[0] != v0 + 1 || key_code !== 4'hE) begin
         n_err++;
         $display("FAIL midpress_repress: events %0d code %h required 1, e", vcnt[0] - v0, key_code);
      end
      keys[1][3] = 1'b0;
      repeat (4) step();
      mcol[0] = 0;
   endtask

   task automatic test_random(input bit lin, input int iters);
      int deb, c, r, hold, v0;
      deb = lin ? 2 : 4;
      for (int it = 0; it < iters; it++) begin
         c = int'($urandom_range(0, ncols(lin) - 1));
         r = int'($urandom_range(0, lin ? 2 : 3));
         hold = int'($urandom_range(0, 3));
         goto_col(lin, c);
         v0 = vcnt[lin];
         set_key(lin, r, c, 1'b1);
         repeat (deb) step();
         n_cmp++;
         if (vcnt[lin] != v0 + 1 || cur_code(lin) !== 4'(exp_code(lin, c, r))) begin
            n_err++;
            $display("FAIL rand_accept_%0d_c%0d_r%0d: events %0d code %0d required 1, %0d", lin, c, r, vcnt[lin] - v0, cur_code(lin), exp_code(lin, c, r));
         end
         repeat (hold) step();
         set_key(lin, r, c, 1'b0);
         repeat (deb - 1) step();
         n_cmp++;
         if (vcnt[lin] != v0 + 1 || cur_held(lin) !== 1'b1) begin
            n_err++;
            $display("FAIL rand_hold_%0d: events %0d held %b required 1, 1", lin, vcnt[lin] - v0, cur_held(lin));
         end
         step();
         mcol[lin] = (c + 1) % ncols(lin);
         n_cmp++;
         if (cur_held(lin) !== 1'b0 || cur_col(lin) !== exp_col(mcol[lin])) begin
            n_err++;
            $display("FAIL rand_release_%0d: held %b col %b required 0, %b", lin, cur_held(lin), cur_col(lin), exp_col(mcol[lin]));
         end
      end
   endtask

   task automatic test_linear();
      int v0;
      goto_col(1, 4);
      n_cmp++;
      if (col_n_l !== 5'b01111) begin
         n_err++;
         $display("FAIL lin_last_col: got %b required 01111", col_n_l);
      end
      v0 = vcnt[1];
      keys_l[2][4] = 1'b1;
      repeat (2) step();
      n_cmp++;
      if (vcnt[1] != v0 + 1 || key_code_l !== 4'd14 || multi_err_l !== 1'b0) begin
         n_err++;
         $display("FAIL lin_accept: events %0d code %0d merr %b required 1, 14, 0", vcnt[1] - v0, key_code_l, multi_err_l);
      end
      keys_l[2][4] = 1'b0;
      repeat (2) step();
      mcol[1] = 0;
      n_cmp++;
      if (col_n_l !== 5'b11110 || key_held_l !== 1'b0) begin
         n_err++;
         $display("FAIL lin_wrap: col %b held %b required 11110, 0", col_n_l, key_held_l);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_multi();
      test_reset_mid_press();
      do_reset();
      test_random(1'b0, 6);
      do_reset();
      test_linear();
      test_random(1'b1, 6);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
